// File: rtl/eda_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
// Build-time defaults are supplied here only when the global define header
// has not already set them.
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

package eda_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Next priority pointer: one past the granted lane, wrapping to 0.
    function automatic int unsigned arb_next_ptr(input int unsigned idx,
                                                 input int unsigned num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/eda_one_hot_to_bin.sv
// One-hot to binary index encoder; all-zero input yields index 0.
module eda_one_hot_to_bin #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_onehot,
    output logic [IDX_WIDTH-1:0] o_bin
);

    // OR together the indices of all set bits (exactly one for valid input).
    always_comb begin
        o_bin = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i_onehot[i]) begin
                o_bin = o_bin | IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/eda_rr_arbiter.sv
// Round-robin arbiter: rotating-priority pick among NUM_REQ lanes, grant
// held until the shared resource pulses done.
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

module eda_rr_arbiter
    import eda_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = `CFG_N,
    parameter int unsigned IDX_WIDTH = `CFG_J_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 busy
);

    arb_state_e                 r_state;
    logic [NUM_REQ-1:0]         r_grant;
    logic [IDX_WIDTH-1:0]       r_ptr;

    logic [2*NUM_REQ-1:0]       w_req2;
    logic [NUM_REQ-1:0]         w_sel;
    logic                       w_found;
    logic [IDX_WIDTH-1:0]       w_grant_idx;

    assign w_req2 = {req, req};

    // Double-width scan: bits below ptr are masked, so the first set bit at or
    // above ptr in {req,req} is the rotating-priority winner (index mod N).
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < 2 * NUM_REQ; k++) begin
            if (!w_found && w_req2[k] && (k >= 32'(r_ptr))) begin
                w_found             = 1'b1;
                w_sel[k % NUM_REQ]  = 1'b1;
            end
        end
    end

    // Two-state grant FSM with priority pointer update on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|req) begin
                        r_grant <= w_sel;
                        r_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (done) begin
                        r_grant <= '0;
                        r_ptr   <= IDX_WIDTH'(arb_next_ptr(32'(w_grant_idx), NUM_REQ));
                        r_state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    eda_one_hot_to_bin #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_one_hot_to_bin (
        .i_onehot (r_grant),
        .o_bin    (w_grant_idx)
    );

    assign grant       = r_grant;
    assign grant_idx   = w_grant_idx;
    assign grant_valid = |r_grant;
    assign busy        = (r_state == ARB_GRANT);

    // Grant must never have more than one bit set.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

endmodule

// File: tb/tb_eda_rr_arbiter.sv
// Directed and randomized check of eda_rr_arbiter with NUM_REQ = 4.
module tb_eda_rr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic [W-1:0] grant_idx;
    logic         grant_valid;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    eda_rr_arbiter #(
        .NUM_REQ   (N),
        .IDX_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Reference model state for the random phase
    logic [N-1:0] m_grant;
    int unsigned  m_idx;
    int unsigned  m_ptr;
    logic         m_busy;
    int unsigned  wait_cnt [N];

    task automatic model_step(input logic [N-1:0] r, input logic d);
        int unsigned k;
        if (!m_busy) begin
            if (r != '0) begin
                for (int j = 0; j < int'(N); j++) begin
                    k = (m_ptr + j) % N;
                    if (!m_busy && r[k]) begin
                        m_busy  = 1'b1;
                        m_idx   = k;
                        m_grant = '0;
                        m_grant[k] = 1'b1;
                    end
                end
            end
        end else if (d) begin
            m_ptr   = (m_idx + 1) % N;
            m_grant = '0;
            m_busy  = 1'b0;
        end
    endtask

    function automatic int unsigned decode(input logic [N-1:0] g);
        int unsigned r = 0;
        for (int i = 0; i < int'(N); i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [N-1:0] prev_grant;
        logic [N-1:0] r_pre;
        int unsigned  seq [5] = '{0, 1, 2, 3, 0};

        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_idx",   32'(grant_idx), 0);
        check("rst_valid", 32'(grant_valid), 0);
        check("rst_busy",  32'(busy), 0);
        rst = 1'b0;

        // Single request on lane 2
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'h4);
        check("single_idx",   32'(grant_idx), 2);
        check("single_busy",  32'(busy), 1);
        check("single_valid", 32'(grant_valid), 1);
        pulse_done();
        check("single_clear", 32'(grant), 0);
        check("single_busy0", 32'(busy), 0);

        // ptr is now 3: req 0011 wraps to lane 0, then lane 1
        req = 4'b0011;
        tick();
        check("wrap_idx0", 32'(grant_idx), 0);
        pulse_done();
        check("wrap_idle", 32'(grant), 0);
        tick();
        check("skip_idx1", 32'(grant_idx), 1);
        pulse_done();

        // Rotation from a fresh reset with all lanes requesting
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rot_idx",   32'(grant_idx), 32'(seq[i]));
            check("rot_grant", 32'(grant), 32'(1) << seq[i]);
            pulse_done();
            check("rot_gap",   32'(grant), 0);
        end

        // ptr = 1: lane 1 granted, then drops its request
        req = 4'b0010;
        tick();
        check("drop_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        tick();
        check("drop_hold",  32'(grant), 32'h2);
        check("drop_busy",  32'(busy), 1);
        pulse_done();
        check("drop_clear", 32'(grant), 0);
        // done while idle: nothing happens
        pulse_done();
        check("idle_done_grant", 32'(grant), 0);
        check("idle_done_busy",  32'(busy), 0);
        req = 4'b0101;
        tick();
        check("after_idle_done_idx", 32'(grant_idx), 2);

        // Asynchronous reset mid-grant (ptr is 2 here)
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 0);
        check("arst_valid", 32'(grant_valid), 0);
        check("arst_busy",  32'(busy), 0);
        check("arst_idx",   32'(grant_idx), 0);
        #1 rst = 1'b0;
        req = 4'b1001;
        tick();
        check("arst_ptr0_idx", 32'(grant_idx), 0);
        pulse_done();
        req = 4'b1000;
        tick();
        check("arst_lane3_idx", 32'(grant_idx), 3);
        pulse_done();

        // Random phase against the reference model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = '0;
        m_grant = '0;
        m_idx   = 0;
        m_ptr   = 0;
        m_busy  = 1'b0;
        for (int i = 0; i < int'(N); i++) wait_cnt[i] = 0;
        prev_grant = '0;
        for (int c = 0; c < 10000; c++) begin
            req  = N'($urandom_range(0, 15));
            done = ($urandom_range(0, 2) == 0);
            r_pre = req;
            model_step(req, done);
            tick();
            check("rnd_grant",   32'(grant), 32'(m_grant));
            check("rnd_busy",    32'(busy), 32'(m_busy));
            check("rnd_valid",   32'(grant_valid), 32'(grant != '0));
            check("rnd_onehot0", 32'($onehot0(grant)), 1);
            check("rnd_idx",     32'(grant_idx), decode(grant));
            for (int i = 0; i < int'(N); i++) if (!r_pre[i]) wait_cnt[i] = 0;
            if (prev_grant == '0 && grant != '0) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (grant[i]) wait_cnt[i] = 0;
                    else if (r_pre[i]) wait_cnt[i]++;
                    check("rnd_fair", 32'(wait_cnt[i] <= N - 1), 1);
                end
            end
            prev_grant = grant;
        end
        done = 1'b0;
        req  = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eda_rr_arbiter.md
# eda_rr_arbiter

Round-robin arbiter sharing one regional-maxima processing resource among `NUM_REQ` requesters (one per column lane). It picks one requester per transaction with rotating priority and holds the grant until the resource signals completion. It outputs the grant as one-hot and as a binary index, which drives the resource's lane-select mux.

## Interface
- `NUM_REQ`, default `` `CFG_N ``: number of requesters; must be ≥ 2.
- `IDX_WIDTH`, default `` `CFG_J_WIDTH ``: width of the binary grant index; must satisfy 2^IDX_WIDTH ≥ NUM_REQ.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, NUM_REQ: per-requester level request; bit i = requester i.
- `done`, input, 1: one-cycle pulse from the resource; the current transaction is finished.
- `grant`, output, NUM_REQ: registered one-hot grant; all-zero when nothing is granted.
- `grant_idx`, output, IDX_WIDTH: binary index of the set `grant` bit; 0 when `grant` is zero.
- `grant_valid`, output, 1: high exactly when `grant` is non-zero.
- `busy`, output, 1: high when the FSM is in GRANT; equals `grant_valid`.

## Operation
- **Reset values:** state = IDLE, `grant` = 0, `grant_idx` = 0, `grant_valid` = 0, `busy` = 0, priority pointer `ptr` = 0.
- **FSM has two states.**
- **IDLE:**
  - If `req` ≠ 0, select the first set bit scanning i = ptr, ptr+1, …, NUM_REQ−1, 0, …, ptr−1.
  - Register that bit as `grant` and move to GRANT.
  - If `req` = 0, stay in IDLE.
  - `done` is ignored in IDLE.
- **GRANT:**
  - `grant` is held constant regardless of `req`. A requester dropping `req` does not revoke its grant.
  - On `done` = 1: clear `grant`, set `ptr` = (granted index + 1) mod NUM_REQ, and return to IDLE.
  - Wrap-around: granted index NUM_REQ−1 gives ptr = 0.
- **Fairness:** a continuously requesting lane waits at most NUM_REQ−1 transactions.
- **`grant_idx`:** combinational decode of the registered `grant` through `eda_one_hot_to_bin`. It is therefore a pure function of registered state and glitch-free relative to `clk`.
- **Invariant:** `grant` is always one-hot or zero; assert this in RTL.

## Timing
- **Grant latency:** if `req` is non-zero at rising edge k while the FSM is in IDLE, then `grant`, `grant_valid` and `busy` are high after edge k, i.e. during cycle k+1.
- **Release:** `done` sampled high at edge m clears the grant after edge m.
- **Turnaround:** the next grant appears no earlier than after edge m+1. There is one mandatory IDLE cycle between transactions.
- **Minimum transaction length:** 1 cycle; `done` may arrive in the first GRANT cycle.
- **Simultaneous events:**
  - `req` changes in the same cycle as `done`: the change is seen in the following IDLE cycle.
  - New `req` bits set during GRANT are not lost, because requests are levels.
- **Reset mid-transaction:** asynchronous assertion immediately clears `grant`, `grant_valid`, `busy` and `ptr`. The resource must treat loss of `grant_valid` as an abort.
- **`done` while `grant_valid` = 0:** no effect.

## Structure
- Shared package `eda_arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e`
  - the ptr-increment/wrap helper function.
- `CFG_N` and `CFG_J_WIDTH` stay in `eda_global_define.svh`.
- One sub-module instance, `eda_one_hot_to_bin`, converts the registered `grant` to `grant_idx`.
- Rotating-priority selection is implemented in-module as a double-width masked priority scan: req concatenated with itself, masked from ptr.

## Test plan
All scenarios use NUM_REQ = 4.
- **Reset, then single request:** after reset, `req` = 4'b0100 → after next edge `grant` = 4'b0100, `grant_idx` = 2, `busy` = 1. Pulse `done` → grant clears, ptr = 3.
- **Rotation:** hold `req` = 4'b1111 and pulse `done` at the end of every grant → grant sequence idx 0, 1, 2, 3, 0, with exactly one IDLE cycle between grants.
- **Wrap and skip:** with ptr = 3 and `req` = 4'b0011 → grant idx 0. After `done` → idx 1.
- **Requester drops request:** drop `req` of the granted lane mid-GRANT → `grant` stays until `done`. A `done` pulse while IDLE → no state change.
- **Async reset mid-GRANT:** assert `rst` between edges → all outputs 0 immediately. After release with `req` = 4'b1000 → grant idx 3 (ptr reset to 0).
- **Random check:** 10k cycles of random `req`/`done` → `grant` is always one-hot or zero, `grant_idx` is consistent with `grant`, and no requester waits more than 3 transactions while requesting.
